main_fsm: RTL and testbench
===========================

Name: main_fsm

Overview:
Multicycle control state machine for the processor's control unit.
- Sequences fetch, decode, execute, memory and writeback steps for every instruction.
- Emits the unconditioned write enables (NextPC, RegW, MemW, FPUW, Branch) consumed by the downstream condition-logic stage, which gates them with the registered condition result.
- Also drives datapath mux selects, and runs a start/done handshake with the multi-cycle FPU.

Parameters:
FPU_TIMEOUT, 16, maximum cycles spent in FPUEX waiting for FPUDone before abort (>=2).
CNT_W, 5, width of the FPU wait counter; must hold FPU_TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 FPU.
Funct  input  6  instruction Funct field; Funct[5] = immediate (I), Funct[0] = load (L).
FPUDone  input  1  FPU result valid; sampled only in FPUEX.
IRWrite  output  1  instruction register load enable.
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
ALUSrcA  output  2  ALU A select: 00 register, 01 PC, 10 ALUOut.
ALUSrcB  output  2  ALU B select: 00 register, 01 extended immediate, 10 constant 4.
ResultSrc  output  2  result select: 00 ALUOut, 01 read data, 10 ALU result.
ALUOp  output  1  1 = ALU decoder uses Funct; 0 = forced add.
NextPC  output  1  unconditional PC write (fetch).
RegW  output  1  register-file write request (pre-condition).
MemW  output  1  memory write request (pre-condition).
Branch  output  1  conditional PC write request (becomes PCS downstream).
FPUW  output  1  FPU register write request (pre-condition).
FPUStart  output  1  single-cycle FPU launch pulse.
FPUErr  output  1  sticky flag: an FPU operation timed out.

Behaviour:
- Moore machine. State register and wait counter are reset asynchronously when reset = 0; all other logic is synchronous to the rising clk edge.
- Reset state is FETCH. Outputs during reset are FETCH's outputs. FPUErr = 0, counter = 0.
- Any output not listed for a state is 0.
- State outputs and transitions:
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next by Op:
    - 00 with Funct[5]=0 -> EXECUTER; with Funct[5]=1 -> EXECUTEI.
    - 01 -> MEMADR.
    - 10 -> BRANCH.
    - 11 -> FPUEX.
  - MEMADR: ALUSrcA=00, ALUSrcB=01. Next: MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD: AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
  - MEMWR: AdrSrc=1, MemW=1. Next: FETCH.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next: ALUWB.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegW=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1. Next: FETCH.
  - FPUEX:
    - FPUStart=1 only in the first cycle of the visit; the counter is cleared on entry.
    - Counter increments each cycle FPUDone=0.
    - FPUDone=1 -> FPUWB. This includes FPUDone=1 in the first cycle, giving minimum FPU latency 1.
    - Counter reaching FPU_TIMEOUT-1 with FPUDone=0 -> FETCH, and FPUErr set.
    - If FPUDone=1 and timeout occur in the same cycle, FPUDone wins -> FPUWB.
  - FPUWB: FPUW=1. Next: FETCH.
- FPUErr is sticky until reset. A timed-out instruction performs no writes.
- Any illegal state encoding -> FETCH on the next edge; outputs are all 0 while in it.
- Instruction cycle counts:
  - branch 3; data-processing 4; store 4; load 5.
  - FPU = 3 + FPUEX cycles (minimum 4).
- Reset asserted mid-instruction: immediate return to FETCH and FETCH outputs. No further write enables issue until a new instruction is fetched.
- Op and Funct are sampled only in DECODE and MEMADR. FPUDone is ignored outside FPUEX.

Test Plan:
1. Release reset, Op=00, Funct[5]=0 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. NextPC=1 only in cycle 0; RegW=1 only in cycle 3; ALUOp=1 only in cycle 2.
2. Op=01, Funct[0]=1 then Funct[0]=0 -> load: RegW=1 with ResultSrc=01 in cycle 4. Store: MemW=1 with AdrSrc=1 in cycle 3. MemW is never 1 during the load.
3. Op=10 -> Branch=1, ALUSrcA=10, ALUSrcB=01 in cycle 2; back in FETCH at cycle 3.
4. Op=11, FPUDone asserted after 3 wait cycles -> FPUStart high exactly 1 cycle; FPUW=1 exactly 1 cycle after FPUDone is seen; FPUErr stays 0.
5. Op=11, FPUDone held 0 with FPU_TIMEOUT=16 -> leaves FPUEX after 16 cycles to FETCH, FPUErr=1, FPUW never 1. A following data-processing instruction still completes normally.
6. Assert reset=0 during MEMWR and during FPUEX -> asynchronous return to FETCH outputs before the next edge; MemW and FPUW drop to 0 immediately; FPUErr cleared.

Source files
------------

// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm : multicycle control unit sequencer.
//
// Steps every instruction through fetch / decode / execute / memory /
// writeback and drives the datapath selects plus the pre-condition write
// requests (NextPC, RegW, MemW, Branch, FPUW) for the condition-logic stage.
// FPU instructions use a start/done handshake with a bounded wait.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   Op         instruction class (00 DP, 01 MEM, 10 BRANCH, 11 FPU)
//   Funct      Funct field; [5] immediate, [0] load
//   FPUDone    FPU result valid, looked at only while waiting in FPUEX
//   IRWrite    instruction register load
//   AdrSrc     memory address select (0 PC, 1 ALUOut)
//   ALUSrcA    ALU A select (00 reg, 01 PC, 10 ALUOut)
//   ALUSrcB    ALU B select (00 reg, 01 ext imm, 10 const 4)
//   ResultSrc  result select (00 ALUOut, 01 read data, 10 ALU result)
//   ALUOp      1 = ALU decoder uses Funct, 0 = add
//   NextPC     unconditional PC write
//   RegW       register write request
//   MemW       memory write request
//   Branch     conditional PC write request
//   FPUW       FPU register write request
//   FPUStart   one-cycle FPU launch pulse
//   FPUErr     sticky FPU timeout flag
//
// All outputs are registered; each is loaded with the decode of the state
// being entered, so outputs always line up with the state register.
// -----------------------------------------------------------------------------
module main_fsm #(
    parameter int unsigned FPU_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       FPUDone,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       FPUW,
    output logic       FPUStart,
    output logic       FPUErr
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FPUEX  = 4'd10,
        S_FPUWB  = 4'd11
    } state_t;

    // Last counter value allowed before the FPU wait is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_TIMEOUT - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             err_nx;

    logic       irwrite_nx;
    logic       adrsrc_nx;
    logic [1:0] alusrca_nx;
    logic [1:0] alusrcb_nx;
    logic [1:0] resultsrc_nx;
    logic       aluop_nx;
    logic       nextpc_nx;
    logic       regw_nx;
    logic       memw_nx;
    logic       branch_nx;
    logic       fpuw_nx;
    logic       fpustart_nx;

    // Funct[4:1] belong to the ALU decoder, not to sequencing.
    logic funct_unused;
    assign funct_unused = ^Funct[4:1];

    // Next state, FPU wait counter and error flag.
    always_comb begin
        state_nx = S_FETCH;
        cnt_nx   = '0;
        err_nx   = FPUErr;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_nx = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_nx = S_MEMADR;
                    2'b10:   state_nx = S_BRANCH;
                    default: state_nx = S_FPUEX;
                endcase
            end
            S_MEMADR: state_nx = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nx = S_MEMWB;
            S_MEMWB:  state_nx = S_FETCH;
            S_MEMWR:  state_nx = S_FETCH;
            S_EXECR:  state_nx = S_ALUWB;
            S_EXECI:  state_nx = S_ALUWB;
            S_ALUWB:  state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_FPUEX: begin
                // Done has priority over a timeout in the same cycle.
                if (FPUDone) begin
                    state_nx = S_FPUWB;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_FETCH;
                    err_nx   = 1'b1;
                end else begin
                    state_nx = S_FPUEX;
                    cnt_nx   = cnt + CNT_W'(1);
                end
            end
            S_FPUWB:  state_nx = S_FETCH;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Moore decode of the state being entered.
    always_comb begin
        irwrite_nx   = 1'b0;
        adrsrc_nx    = 1'b0;
        alusrca_nx   = 2'b00;
        alusrcb_nx   = 2'b00;
        resultsrc_nx = 2'b00;
        aluop_nx     = 1'b0;
        nextpc_nx    = 1'b0;
        regw_nx      = 1'b0;
        memw_nx      = 1'b0;
        branch_nx    = 1'b0;
        fpuw_nx      = 1'b0;
        fpustart_nx  = 1'b0;
        case (state_nx)
            S_FETCH: begin
                irwrite_nx   = 1'b1;
                alusrca_nx   = 2'b01;
                alusrcb_nx   = 2'b10;
                resultsrc_nx = 2'b10;
                nextpc_nx    = 1'b1;
            end
            S_DECODE: begin
                alusrca_nx   = 2'b01;
                alusrcb_nx   = 2'b10;
                resultsrc_nx = 2'b10;
            end
            S_MEMADR: begin
                alusrcb_nx = 2'b01;
            end
            S_MEMRD: begin
                adrsrc_nx = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_nx = 2'b01;
                regw_nx      = 1'b1;
            end
            S_MEMWR: begin
                adrsrc_nx = 1'b1;
                memw_nx   = 1'b1;
            end
            S_EXECR: begin
                aluop_nx = 1'b1;
            end
            S_EXECI: begin
                alusrcb_nx = 2'b01;
                aluop_nx   = 1'b1;
            end
            S_ALUWB: begin
                regw_nx = 1'b1;
            end
            S_BRANCH: begin
                alusrca_nx   = 2'b10;
                alusrcb_nx   = 2'b01;
                resultsrc_nx = 2'b10;
                branch_nx    = 1'b1;
            end
            S_FPUEX: begin
                // Launch only on entry, not while waiting.
                fpustart_nx = (state != S_FPUEX);
            end
            S_FPUWB: begin
                fpuw_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter, sticky error and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            cnt       <= '0;
            FPUErr    <= 1'b0;
            IRWrite   <= 1'b1;
            AdrSrc    <= 1'b0;
            ALUSrcA   <= 2'b01;
            ALUSrcB   <= 2'b10;
            ResultSrc <= 2'b10;
            ALUOp     <= 1'b0;
            NextPC    <= 1'b1;
            RegW      <= 1'b0;
            MemW      <= 1'b0;
            Branch    <= 1'b0;
            FPUW      <= 1'b0;
            FPUStart  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            FPUErr    <= err_nx;
            IRWrite   <= irwrite_nx;
            AdrSrc    <= adrsrc_nx;
            ALUSrcA   <= alusrca_nx;
            ALUSrcB   <= alusrcb_nx;
            ResultSrc <= resultsrc_nx;
            ALUOp     <= aluop_nx;
            NextPC    <= nextpc_nx;
            RegW      <= regw_nx;
            MemW      <= memw_nx;
            Branch    <= branch_nx;
            FPUW      <= fpuw_nx;
            FPUStart  <= fpustart_nx;
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_fsm : self-checking bench for main_fsm.
// Builds, per instruction, the expected per-cycle output sequence from the
// instruction class and compares it against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_main_fsm;

    localparam int unsigned TO = 16;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       FPUDone;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, FPUW, FPUStart, FPUErr;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    main_fsm #(.FPU_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .FPUDone  (FPUDone),
        .IRWrite  (IRWrite),
        .AdrSrc   (AdrSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ResultSrc(ResultSrc),
        .ALUOp    (ALUOp),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .Branch   (Branch),
        .FPUW     (FPUW),
        .FPUStart (FPUStart),
        .FPUErr   (FPUErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, FPUW, FPUStart, FPUErr}
    logic [15:0] outs;
    assign outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                   NextPC, RegW, MemW, Branch, FPUW, FPUStart, FPUErr};

    function automatic logic [15:0] v(input bit ir, input bit adr, input bit [1:0] sa,
                                      input bit [1:0] sb, input bit [1:0] rs, input bit aop,
                                      input bit npc, input bit rw, input bit mw, input bit br,
                                      input bit fw, input bit fs);
        return {ir, adr, sa, sb, rs, aop, npc, rw, mw, br, fw, fs, 1'b0};
    endfunction

    // Per-step output table.
    logic [15:0] V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR;
    logic [15:0] V_EXECR, V_EXECI, V_ALUWB, V_BRANCH, V_FPUEX, V_FPUWB;
    initial begin
        V_FETCH  = v(1, 0, 2'b01, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0, 0);
        V_DECODE = v(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        V_MEMADR = v(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_MEMRD  = v(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_MEMWB  = v(0, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 0);
        V_MEMWR  = v(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0);
        V_EXECR  = v(0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        V_EXECI  = v(0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        V_ALUWB  = v(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        V_BRANCH = v(0, 0, 2'b10, 2'b01, 2'b10, 0, 0, 0, 0, 1, 0, 0);
        V_FPUEX  = v(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_FPUWB  = v(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    end

    int n_checks = 0;
    int n_errors = 0;
    bit err_m    = 1'b0;   // model of the sticky timeout flag

    logic [15:0] exp_q[$];
    int          fx_q[$];  // 1-based FPUEX wait-cycle index, 0 elsewhere

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // lat: FPUEX cycle in which FPUDone is raised (> TO means never).
    // abort_at: cycle of the instruction in which reset is pulsed (-1 none).
    task automatic run_instr(input string name, input logic [1:0] op, input bit imm,
                             input bit load, input int lat, input int abort_at);
        bit tmo;
        int n_ex;
        tmo = 1'b0;
        exp_q.delete();
        fx_q.delete();
        exp_q.push_back(V_FETCH);  fx_q.push_back(0);
        exp_q.push_back(V_DECODE); fx_q.push_back(0);
        case (op)
            2'b00: begin
                exp_q.push_back(imm ? V_EXECI : V_EXECR); fx_q.push_back(0);
                exp_q.push_back(V_ALUWB);                 fx_q.push_back(0);
            end
            2'b01: begin
                exp_q.push_back(V_MEMADR); fx_q.push_back(0);
                if (load) begin
                    exp_q.push_back(V_MEMRD); fx_q.push_back(0);
                    exp_q.push_back(V_MEMWB); fx_q.push_back(0);
                end else begin
                    exp_q.push_back(V_MEMWR); fx_q.push_back(0);
                end
            end
            2'b10: begin
                exp_q.push_back(V_BRANCH); fx_q.push_back(0);
            end
            default: begin
                tmo  = (lat > int'(TO));
                n_ex = tmo ? int'(TO) : lat;
                for (int i = 1; i <= n_ex; i++) begin
                    exp_q.push_back(V_FPUEX | ((i == 1) ? 16'h0002 : 16'h0000));
                    fx_q.push_back(i);
                end
                if (!tmo) begin
                    exp_q.push_back(V_FPUWB); fx_q.push_back(0);
                end
            end
        endcase

        for (int j = 0; j < exp_q.size(); j++) begin
            if (j == abort_at) begin
                #2 reset = 1'b0;
                err_m = 1'b0;
                #1 check($sformatf("%s_rst_async[%0d]", name, j), outs, V_FETCH);
                @(negedge clk);
                check($sformatf("%s_rst_hold[%0d]", name, j), outs, V_FETCH);
                reset = 1'b1;
                return;
            end
            check($sformatf("%s[%0d]", name, j), outs, exp_q[j] | {15'd0, err_m});
            // Op/Funct only matter in DECODE (j=1) and MEMADR (j=2).
            if (j == 1) begin
                Op    = op;
                Funct = {imm, 4'($urandom), load};
            end else if (j != 2) begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end
            FPUDone = (fx_q[j] > 0) ? (fx_q[j] == lat) : 1'($urandom);
            @(negedge clk);
        end
        if (tmo) err_m = 1'b1;
    endtask

    initial begin
        int op, lat, ab;
        reset   = 1'b0;
        Op      = 2'b00;
        Funct   = 6'd0;
        FPUDone = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", outs, V_FETCH);
        reset = 1'b1;

        // Directed cases.
        run_instr("dp_reg",    2'b00, 1'b0, 1'b0, 0, -1);
        run_instr("dp_imm",    2'b00, 1'b1, 1'b0, 0, -1);
        run_instr("load",      2'b01, 1'b0, 1'b1, 0, -1);
        run_instr("store",     2'b01, 1'b1, 1'b0, 0, -1);
        run_instr("branch",    2'b10, 1'b0, 1'b0, 0, -1);
        run_instr("fpu_lat4",  2'b11, 1'b0, 1'b0, 4, -1);
        run_instr("fpu_lat1",  2'b11, 1'b0, 1'b0, 1, -1);
        run_instr("fpu_lat16", 2'b11, 1'b0, 1'b0, int'(TO), -1);
        run_instr("fpu_tmo",   2'b11, 1'b0, 1'b0, 100, -1);
        run_instr("dp_after",  2'b00, 1'b0, 1'b0, 0, -1);
        run_instr("store_rst", 2'b01, 1'b0, 1'b0, 0, 3);
        run_instr("fpu_tmo2",  2'b11, 1'b0, 1'b0, int'(TO) + 1, -1);
        run_instr("fpu_rst",   2'b11, 1'b0, 1'b0, 10, 5);
        run_instr("dp_post",   2'b00, 1'b1, 1'b0, 0, -1);

        // Randomized instruction stream with occasional reset pulses.
        for (int k = 0; k < 80; k++) begin
            op  = $urandom_range(0, 3);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 6);
            ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : -1;
            run_instr($sformatf("rnd%0d", k), 2'(op), 1'($urandom), 1'($urandom), lat, ab);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
